// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: memory-access stage between execute and regfile writeback.
// Sub-word stores are read-modify-write. Optional macro: LSU_MISALIGN_TRAP_EN.
module lsu_mem_stage #(
   parameter int WORD     = 32,
   parameter int ADDR_LEN = 32,
   parameter int REG_ADDR = 5,
   parameter int RD_LAT   = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:0]          in_op,
   input  logic [1:0]          in_size,
   input  logic                in_unsigned,
   input  logic [ADDR_LEN-1:0] in_addr,
   input  logic [WORD-1:0]     in_wdata,
   input  logic [REG_ADDR-1:0] in_rd,
   input  logic                in_rd_we,
   output logic                dmem_w_en,
   output logic [ADDR_LEN-1:0] dmem_waddr,
   output logic [WORD-1:0]     dmem_wdata,
   output logic [ADDR_LEN-1:0] dmem_raddr,
   input  logic [WORD-1:0]     dmem_rdata,
   output logic                wb_valid,
   output logic                wb_we,
   output logic [REG_ADDR-1:0] wb_rd,
   output logic [WORD-1:0]     wb_data,
   output logic                misalign
);
   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] RD_WAIT  = 2'd1;
   localparam logic [1:0] COMMIT   = 2'd2;
   localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

   function automatic logic [WORD-1:0] load_extract(input logic [WORD-1:0] w, input logic [1:0] size,
                                                    input logic uns, input logic [1:0] a);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{a, 3'b000} +: 8];
      h = w[{a[1], 4'b0000} +: 16];
      case (size)
         2'b00:   load_extract = uns ? {{(WORD-8){1'b0}}, b} : {{(WORD-8){b[7]}}, b};
         2'b01:   load_extract = uns ? {{(WORD-16){1'b0}}, h} : {{(WORD-16){h[15]}}, h};
         default: load_extract = w;
      endcase
   endfunction

   function automatic logic [WORD-1:0] store_merge(input logic [WORD-1:0] w, input logic [15:0] d,
                                                   input logic [1:0] size, input logic [1:0] a);
      logic [WORD-1:0] m;
      m = w;
      case (size)
         2'b00:   m[{a, 3'b000} +: 8] = d[7:0];
         2'b01:   m[{a[1], 4'b0000} +: 16] = d;
         default: m = w;
      endcase
      return m;
   endfunction

   logic [1:0]          state;
   logic [2:0]          cnt;
   logic                lat_store;
   logic [1:0]          lat_size;
   logic                lat_uns;
   logic [ADDR_LEN-1:0] lat_addr;
   logic [15:0]         lat_wdata;
   logic [REG_ADDR-1:0] lat_rd;
   logic                lat_rd_we;
   logic                accept;
   logic                in_load;
   logic                in_store;
   logic                in_word;
   logic                in_mis;
   logic                in_read;

   assign in_ready = !reset && ((state == IDLE) || (state == COMMIT));
   assign accept   = in_valid && in_ready;
   assign in_load  = (in_op == 2'b01);
   assign in_store = (in_op == 2'b10);
   assign in_word  = in_size[1];
`ifdef LSU_MISALIGN_TRAP_EN
   assign in_mis   = (in_load || in_store) &&
                     (((in_size == 2'b01) && in_addr[0]) || (in_word && (in_addr[1:0] != 2'b00)));
`else
   assign in_mis   = 1'b0;
`endif
   assign in_read  = (in_load || (in_store && !in_word)) && !in_mis;

   // Request sequencing; every dcache and writeback output is registered here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= 3'd0;
         lat_store  <= 1'b0;
         lat_size   <= 2'b00;
         lat_uns    <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= 16'h0000;
         lat_rd     <= '0;
         lat_rd_we  <= 1'b0;
         dmem_w_en  <= 1'b0;
         dmem_waddr <= '0;
         dmem_wdata <= '0;
         dmem_raddr <= '0;
         wb_valid   <= 1'b0;
         wb_we      <= 1'b0;
         wb_rd      <= '0;
         wb_data    <= '0;
         misalign   <= 1'b0;
      end else begin
         wb_valid  <= 1'b0;
         wb_we     <= 1'b0;
         dmem_w_en <= 1'b0;
         case (state)
            RD_WAIT: begin
               if (cnt == 3'd0) begin
                  state    <= COMMIT;
                  wb_valid <= 1'b1;
                  wb_rd    <= lat_rd;
                  if (lat_store) begin
                     dmem_w_en  <= 1'b1;
                     dmem_waddr <= {lat_addr[ADDR_LEN-1:2], 2'b00};
                     dmem_wdata <= store_merge(dmem_rdata, lat_wdata, lat_size, lat_addr[1:0]);
                     wb_data    <= '0;
                  end else begin
                     wb_we   <= lat_rd_we && (lat_rd != '0);
                     wb_data <= load_extract(dmem_rdata, lat_size, lat_uns, lat_addr[1:0]);
                  end
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            IDLE, COMMIT: begin
               if (accept) begin
                  lat_store <= in_store;
                  lat_size  <= in_size;
                  lat_uns   <= in_unsigned;
                  lat_addr  <= in_addr;
                  lat_wdata <= in_wdata[15:0];
                  lat_rd    <= in_rd;
                  lat_rd_we <= in_rd_we;
                  if (in_mis) begin
                     // Trapped access: complete without touching the dcache.
                     state    <= COMMIT;
                     wb_valid <= 1'b1;
                     wb_rd    <= in_rd;
                     wb_data  <= '0;
                     misalign <= 1'b1;
                  end else if (in_read) begin
                     state      <= RD_WAIT;
                     cnt        <= CNT_INIT;
                     dmem_raddr <= {in_addr[ADDR_LEN-1:2], 2'b00};
                  end else begin
                     state    <= COMMIT;
                     wb_valid <= 1'b1;
                     wb_rd    <= in_rd;
                     wb_we    <= in_rd_we && !in_store && (in_rd != '0);
                     wb_data  <= in_store ? '0 : WORD'(in_addr);
                     if (in_store) begin
                        dmem_w_en  <= 1'b1;
                        dmem_waddr <= {in_addr[ADDR_LEN-1:2], 2'b00};
                        dmem_wdata <= in_wdata;
                     end else begin
                        dmem_w_en <= 1'b0;
                     end
                  end
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
